// File: rtl/jstk2_pkg.sv
// Shared types and constants for the PmodJSTK2 poll controller.
// Optional build macro used by this block: JSTK2_LED_EN (LED command frame).
package jstk2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEND,
      WAIT,
      GAP,
      HOLD
   } jstk2_state_t;

   localparam int JSTK2_FRAME_BYTES = 5;

   localparam logic [7:0] JSTK2_CMD_LED = 8'h84;
   localparam logic [7:0] JSTK2_CMD_NOP = 8'h00;

   typedef logic [2:0] jstk2_idx_t;

   localparam jstk2_idx_t JSTK2_LAST_IDX = jstk2_idx_t'(JSTK2_FRAME_BYTES - 1);

   // Saturating subtract, used to turn cycle budgets into timer load values
   function automatic int sat_sub(input int a, input int b);
      return (a > b) ? a - b : 0;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/jstk2_delay_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
// A load of 0 therefore reports done on the very next cycle.
module jstk2_delay_timer #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             done
);

   logic [WIDTH-1:0] cnt;

   // Count the loaded value down to zero and park there
   always_ff @(posedge clk) begin
      // NOTE: registers take <= so every flop samples pre-edge values; = here would chain updates within one edge.
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/jstk2_poll_ctrl.sv
// PmodJSTK2 transaction sequencer: polls a 5-byte SPI frame through an
// external byte engine, owns SS and inter-byte timing, decodes x/y/buttons.
// Build macro: JSTK2_LED_EN sends {0x84,R,G,B,0x00}; otherwise five 0x00.
module jstk2_poll_ctrl
   import jstk2_pkg::*;
#(
   parameter int POLL_CYC     = 1_000_000,
   parameter int SS_SETUP_CYC = 1500,
   parameter int BYTE_GAP_CYC = 1000,
   parameter int SS_HOLD_CYC  = 2500,
   parameter int TIMEOUT_CYC  = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        byte_start,
   output logic [7:0]  byte_tx,
   input  logic [7:0]  byte_rx,
   input  logic        byte_done,
   output logic        SS,
   output logic [9:0]  x_val,
   output logic [9:0]  y_val,
   output logic [1:0]  btn,
   output logic        sample_valid,
   output logic        err,
   input  logic [23:0] led_rgb
);

   // Load values absorb the FSM's own transition cycles so that the
   // observable SS/byte_start spacing equals the parameter exactly.
   localparam int SETUP_LD = sat_sub(SS_SETUP_CYC, 1);
   localparam int GAP_LD   = sat_sub(BYTE_GAP_CYC, 2);
   localparam int HOLD_LD  = sat_sub(SS_HOLD_CYC, 2);
   localparam int TW       = $clog2(max3(SETUP_LD, GAP_LD, HOLD_LD) + 2);
   localparam int PW       = $clog2(POLL_CYC + 1);
   localparam int OW       = $clog2(TIMEOUT_CYC + 1);

   jstk2_state_t   state;
   jstk2_idx_t     idx;
   logic [PW-1:0]  poll_cnt;
   logic           poll_tick;
   logic [OW-1:0]  to_cnt;
   logic           to_expired;
   logic           tmr_load;
   logic [TW-1:0]  tmr_value;
   logic           tmr_done;
   logic [7:0]     tx_byte;
   logic [7:0]     rx [0:3];
   logic           unused_rx_hi;

   assign poll_tick  = en && (poll_cnt == PW'(POLL_CYC - 1));
   assign to_expired = (to_cnt == OW'(TIMEOUT_CYC - 1));

   // Free-running poll period, held at zero while polling is disabled
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         poll_cnt <= '0;
      end else if (poll_tick) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + 1'b1;
      end
   end

`ifdef JSTK2_LED_EN
   logic [23:0] led_q;

   // Freeze the colour at the SS-falling cycle so one frame is consistent
   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
      end else if (state == IDLE && poll_tick) begin
         led_q <= led_rgb;
      end
   end

   // Select the transmit byte for the current index
   always_comb begin
      case (idx)
         3'd0:    tx_byte = JSTK2_CMD_LED;
         3'd1:    tx_byte = led_q[23:16];
         3'd2:    tx_byte = led_q[15:8];
         3'd3:    tx_byte = led_q[7:0];
         default: tx_byte = JSTK2_CMD_NOP;
      endcase
   end
`else
   logic unused_led;
   assign unused_led = ^led_rgb;
   assign tx_byte    = JSTK2_CMD_NOP;
`endif

   // Timer reloads on the edge that enters SETUP, GAP or HOLD
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state)
         IDLE: begin
            if (poll_tick) begin
               tmr_load  = 1'b1;
               tmr_value = TW'(SETUP_LD);
            end
         end
         WAIT: begin
            if (byte_done) begin
               tmr_load  = 1'b1;
               tmr_value = (idx == JSTK2_LAST_IDX) ? TW'(HOLD_LD) : TW'(GAP_LD);
            end else if (to_expired) begin
               tmr_load  = 1'b1;
               tmr_value = TW'(HOLD_LD);
            end
         end
         default: ;
      endcase
   end

   jstk2_delay_timer #(.WIDTH(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done)
   );

   // Capture bytes 0..3; byte 4 is decoded straight from byte_rx at commit
   always_ff @(posedge clk) begin
      // NOTE: rx is a data store overwritten before every commit, so it carries no reset.
      if (state == WAIT && byte_done && idx != JSTK2_LAST_IDX) begin
         rx[idx[1:0]] <= byte_rx;
      end
   end

   assign unused_rx_hi = ^{rx[1][7:2], rx[3][7:2]};

   // Frame sequencer with registered SS, strobes and decoded outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         to_cnt       <= '0;
         SS           <= 1'b1;
         byte_start   <= 1'b0;
         byte_tx      <= '0;
         x_val        <= '0;
         y_val        <= '0;
         btn          <= '0;
         sample_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         byte_start   <= 1'b0;
         sample_valid <= 1'b0;
         err          <= 1'b0;
         case (state)
            IDLE: begin
               if (poll_tick) begin
                  SS    <= 1'b0;
                  idx   <= '0;
                  state <= SETUP;
               end
            end
            SETUP, GAP: begin
               if (tmr_done) begin
                  byte_start <= 1'b1;
                  byte_tx    <= tx_byte;
                  state      <= SEND;
               end
            end
            SEND: begin
               to_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (byte_done) begin
                  if (idx != JSTK2_LAST_IDX) begin
                     idx   <= idx + 1'b1;
                     state <= GAP;
                  end else begin
                     SS           <= 1'b1;
                     x_val        <= {rx[1][1:0], rx[0]};
                     y_val        <= {rx[3][1:0], rx[2]};
                     btn          <= byte_rx[1:0];
                     sample_valid <= 1'b1;
                     state        <= HOLD;
                  end
               end else if (to_expired) begin
                  SS    <= 1'b1;
                  err   <= 1'b1;
                  state <= HOLD;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (tmr_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jstk2_poll_ctrl.sv
// Directed bench for jstk2_poll_ctrl with a behavioural SPI byte engine.
// Honours JSTK2_LED_EN for the expected transmit bytes.
module tb_jstk2_poll_ctrl;

   localparam int POLL    = 200;
   localparam int SETUP   = 5;
   localparam int GAPC    = 3;
   localparam int HOLDC   = 7;
   localparam int TMO     = 50;
   localparam int ENG_LAT = 8;

   logic        clk;
   logic        rst;
   logic        en;
   logic        byte_start;
   logic [7:0]  byte_tx;
   logic [7:0]  byte_rx;
   logic        byte_done;
   logic        SS;
   logic [9:0]  x_val;
   logic [9:0]  y_val;
   logic [1:0]  btn;
   logic        sample_valid;
   logic        err;
   logic [23:0] led_rgb;

   logic        eng_done;
   logic [7:0]  eng_rx;
   logic        tb_done;
   logic [7:0]  tb_rx;
   logic        spur_gap;
   int          withhold;
   logic [7:0]  rx_tab [5];
   logic [7:0]  exp_tx [5];

   int cyc = 0;
   logic prev_ss = 1'b1;
   int sv_cnt = 0;
   int ss_fall_q[$];
   int ss_rise_q[$];
   int bs_q[$];
   logic [7:0] tx_q[$];
   int sv_q[$];
   int err_q[$];

   int n_checks = 0;
   int n_errors = 0;

   assign byte_done = eng_done | tb_done;
   assign byte_rx   = tb_done ? tb_rx : eng_rx;

   jstk2_poll_ctrl #(
      .POLL_CYC     (POLL),
      .SS_SETUP_CYC (SETUP),
      .BYTE_GAP_CYC (GAPC),
      .SS_HOLD_CYC  (HOLDC),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .byte_start   (byte_start),
      .byte_tx      (byte_tx),
      .byte_rx      (byte_rx),
      .byte_done    (byte_done),
      .SS           (SS),
      .x_val        (x_val),
      .y_val        (y_val),
      .btn          (btn),
      .sample_valid (sample_valid),
      .err          (err),
      .led_rgb      (led_rgb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled mid-cycle; cyc is the cycle index of each event
   always @(negedge clk) begin
      prev_ss <= SS;
      if (prev_ss === 1'b1 && SS === 1'b0) ss_fall_q.push_back(cyc);
      if (prev_ss === 1'b0 && SS === 1'b1) ss_rise_q.push_back(cyc);
      if (byte_start === 1'b1) begin
         bs_q.push_back(cyc);
         tx_q.push_back(byte_tx);
      end
      if (sample_valid === 1'b1) begin
         sv_cnt <= sv_cnt + 1;
         sv_q.push_back(cyc);
      end
      if (err === 1'b1) err_q.push_back(cyc);
   end

   // Byte engine: byte_done ENG_LAT cycles after byte_start, optional
   // withheld byte and optional spurious pulse in the following GAP cycle
   initial begin
      int k;
      int kk;
      k = 0;
      eng_done = 1'b0;
      eng_rx = 8'h00;
      forever begin
         @(negedge clk);
         if (SS === 1'b1 || rst === 1'b1) begin
            k = 0;
         end else if (byte_start === 1'b1) begin
            kk = k;
            k++;
            repeat (ENG_LAT) @(negedge clk);
            if (kk != withhold && rst !== 1'b1 && kk < 5) begin
               eng_rx = rx_tab[kk];
               eng_done = 1'b1;
               @(negedge clk);
               eng_done = 1'b0;
               if (spur_gap) begin
                  eng_rx = 8'h55;
                  eng_done = 1'b1;
                  @(negedge clk);
                  eng_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      led_rgb = 24'h10_20_30;
      tb_done = 1'b0;
      tb_rx = 8'h00;
      spur_gap = 1'b0;
      withhold = 99;
      rx_tab = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef JSTK2_LED_EN
      exp_tx = '{8'h84, 8'h10, 8'h20, 8'h30, 8'h00};
`else
      exp_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ss", SS, 1);
      check("rst_byte_start", byte_start, 0);
      check("rst_byte_tx", byte_tx, 0);
      check("rst_x", x_val, 0);
      check("rst_y", y_val, 0);
      check("rst_btn", btn, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_err", err, 0);
      rst = 1'b0;

      // Spurious byte_done while IDLE
      @(negedge clk);
      tb_rx = 8'hAA;
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_spur_sv", sv_cnt, 0);
      check("idle_spur_bytes", bs_q.size(), 0);
      check("idle_spur_ss", SS, 1);

      // Frame 1: timing, decode, spurious byte_done in GAP
      rx_tab = '{8'hFF, 8'h03, 8'h00, 8'h02, 8'h03};
      spur_gap = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 600 && sv_cnt < 1; i++) @(posedge clk);
      check("f1_sample_count", sv_cnt, 1);
      spur_gap = 1'b0;
      check("f1_nbytes", bs_q.size(), 5);
      if (bs_q.size() >= 5 && ss_fall_q.size() >= 1 && ss_rise_q.size() >= 1 && sv_q.size() >= 1) begin
         check("f1_setup_cycles", bs_q[0] - ss_fall_q[0], SETUP);
         for (int i = 0; i < 4; i++) check($sformatf("f1_byte_spacing%0d", i), bs_q[i+1] - bs_q[i], ENG_LAT + GAPC);
         check("f1_ss_rise", ss_rise_q[0], bs_q[4] + ENG_LAT + 1);
         check("f1_sv_cycle", sv_q[0], bs_q[4] + ENG_LAT + 1);
         for (int i = 0; i < 5; i++) check($sformatf("f1_tx%0d", i), tx_q[i], exp_tx[i]);
      end
      check("f1_x", x_val, 1023);
      check("f1_y", y_val, 512);
      check("f1_btn", btn, 3);

      // Frame 2: byte 2 withheld -> timeout abort
      rx_tab = '{8'h11, 8'h00, 8'h22, 8'h01, 8'h00};
      withhold = 2;
      for (int i = 0; i < 600 && err_q.size() < 1; i++) @(posedge clk);
      check("f2_err_count", err_q.size(), 1);
      repeat (3) @(posedge clk);
      check("f2_nbytes", bs_q.size(), 8);
      if (err_q.size() >= 1 && bs_q.size() >= 8 && ss_rise_q.size() >= 2 && ss_fall_q.size() >= 2) begin
         check("f2_err_latency", err_q[0] - bs_q[7], TMO + 1);
         check("f2_ss_rise_on_err", ss_rise_q[1], err_q[0]);
         check("f1_hold_min", (ss_fall_q[1] - ss_rise_q[0]) >= HOLDC, 1);
      end
      check("f2_err_single", err_q.size(), 1);
      check("f2_sv_none", sv_cnt, 1);
      check("f2_x_kept", x_val, 1023);
      check("f2_y_kept", y_val, 512);
      check("f2_btn_kept", btn, 3);

      // Frame 3: recovery, masking of upper rx bits, LED change mid-frame
      rx_tab = '{8'h34, 8'hF6, 8'h78, 8'hFD, 8'hFD};
      withhold = 99;
      for (int i = 0; i < 600 && bs_q.size() < 9; i++) @(posedge clk);
      @(negedge clk);
      led_rgb = 24'hAA_BB_CC;
      for (int i = 0; i < 200 && sv_cnt < 2; i++) @(posedge clk);
      check("f3_sample_count", sv_cnt, 2);
      check("f3_x", x_val, 564);
      check("f3_y", y_val, 376);
      check("f3_btn", btn, 1);
      check("f3_nbytes", bs_q.size(), 13);
      if (tx_q.size() >= 13) begin
         for (int i = 0; i < 5; i++) check($sformatf("f3_tx%0d", i), tx_q[8+i], exp_tx[i]);
      end

      // Frame 4: reset asserted in GAP after byte 2 (third byte)
      rx_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 0; i < 600 && bs_q.size() < 16; i++) @(posedge clk);
      check("f4_reach_byte2", bs_q.size(), 16);
      repeat (ENG_LAT + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("f4_rst_ss", SS, 1);
      check("f4_rst_x", x_val, 0);
      check("f4_rst_y", y_val, 0);
      check("f4_rst_btn", btn, 0);
      check("f4_rst_byte_tx", byte_tx, 0);
      check("f4_rst_byte_start", byte_start, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("f4_idle_no_bytes", bs_q.size(), 16);
      check("f4_idle_no_fall", ss_fall_q.size(), 4);
      check("f4_idle_ss", SS, 1);

      // Frame 5: en dropped mid-frame, frame completes, no further frames
      rx_tab = '{8'h01, 8'h01, 8'hFF, 8'h03, 8'h02};
      for (int i = 0; i < 600 && ss_fall_q.size() < 5; i++) @(posedge clk);
      check("f5_started", ss_fall_q.size(), 5);
      repeat (10) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 200 && sv_cnt < 3; i++) @(posedge clk);
      check("f5_sample_count", sv_cnt, 3);
      check("f5_x", x_val, 257);
      check("f5_y", y_val, 1023);
      check("f5_btn", btn, 2);
      repeat (450) @(negedge clk);
      check("f5_no_new_frame", ss_fall_q.size(), 5);
      check("f5_nbytes", bs_q.size(), 21);
      check("f5_ss_idle", SS, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
